imem_port_arbiter: RTL

Two-master arbiter that shares the single req/gnt/rvalid port of the instruction memory between the core fetch unit (master 0) and the trace/debug reader (master 1). It sits directly in front of the memory and allows one outstanding transaction at a time. It latches the winning master, holds the address stable until the memory grants, and routes the grant, read data and valid back to the owner. A response timeout returns an error instead of hanging the owner.

---
 rtl/imem_arb_pkg.sv | 22 ++
 rtl/imem_port_arbiter_arb_rr_select.sv | 28 ++
 rtl/imem_port_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory port arbiter.
// Optional round-robin tie-break: IMEM_ARB_ROUND_ROBIN_EN.
package imem_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef logic master_idx_t;

  function automatic logic [NUM_MASTERS-1:0] idx2oh(
    input master_idx_t idx
  );
    idx2oh = '0;
    idx2oh[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/imem_port_arbiter_arb_rr_select.sv
// Winner pick for the two-master arbiter.
// IMEM_ARB_ROUND_ROBIN_EN selects round-robin ties, else fixed priority.
module arb_rr_select
  import imem_arb_pkg::*;
(
  input  logic [1:0]  req_i,
  input  master_idx_t last_i,
  output master_idx_t winner_o
);

`ifdef IMEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    winner_o = 1'b0;
    unique case (1'b1)
      (&req_i): winner_o = ~last_i;
      req_i[1]: winner_o = 1'b1;
      default:  winner_o = 1'b0;
    endcase
  end
`else
  logic unused_last;
  assign unused_last = last_i;

  // Master 0 always wins; master 1 only when alone.
  assign winner_o = ~req_i[0];
`endif

endmodule

// File: rtl/imem_port_arbiter.sv
// Two-master arbiter in front of the instruction memory port.
// Tie-break policy set by IMEM_ARB_ROUND_ROBIN_EN (see arb_rr_select).
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              m_req_i,
  input  logic [2*ADDR_WIDTH-1:0] m_addr_i,
  output logic [1:0]              m_gnt_o,
  output logic [1:0]              m_rvalid_o,
  output logic [1:0]              m_err_o,
  output logic [DATA_WIDTH-1:0]   m_rdata_o,
  output logic                    s_req_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  input  logic                    s_gnt_i,
  input  logic                    s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  output logic                    busy_o
);

  localparam int CNT_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  arb_state_e       state_q, state_d;
  master_idx_t      owner_q, owner_d;
  master_idx_t      last_q, last_d;
  master_idx_t      winner;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       own_oh;
  logic             to_hit;

  arb_rr_select u_sel (
    .req_i    (m_req_i),
    .last_i   (last_q),
    .winner_o (winner)
  );

  assign own_oh = idx2oh(owner_q);
  assign to_hit = (TIMEOUT_CYCLES != 0) &&
                  (cnt_q == CNT_W'(TO_LAST));
  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    s_req_o    = 1'b0;
    s_addr_o   = '0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_err_o    = '0;
    m_rdata_o  = rst ? '0 : s_rdata_i;
    unique case (state_q)
      IDLE: begin
        if (|m_req_i) begin
          owner_d = winner;
          state_d = REQ;
        end
      end
      REQ: begin
        // Request stays up even if the owner drops req.
        s_req_o  = 1'b1;
        s_addr_o = owner_q ? m_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                           : m_addr_i[ADDR_WIDTH-1:0];
        if (s_gnt_i) begin
          m_gnt_o = own_oh;
          last_d  = owner_q;
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (s_rvalid_i) begin
          m_rvalid_o = own_oh;
          state_d    = IDLE;
        end else if (to_hit) begin
          m_rvalid_o = own_oh;
          m_err_o    = own_oh;
          m_rdata_o  = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
